// File: rtl/conv_pkg.sv
// Shared constants, types and helpers for the conv window generator.
// Optional stride-2 support is enabled by CONV_WINDOW_STRIDE2_EN.
package conv_pkg;

    localparam int W_PAD = 418;
    localparam int DW    = 8;
    localparam int NCH   = 3;
    localparam int K     = 3;

    typedef logic [DW-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    // Left column of the last window that still fits inside the row.
    function automatic logic [8:0] last_col(
        input int   w_pad,
        input logic s2
    );
        int span;
        span = w_pad - K;
        if (s2) begin
            span = (span / 2) * 2;
        end
        return span[8:0];
    endfunction

endpackage

// File: rtl/conv_window_mux.sv
// Combinational extraction of a KxKxNCH window from NCH*K flat rows.
// Built on conv_pkg; no configuration macros affect this file.
module conv_window_mux
    import conv_pkg::*;
#(
    parameter int W = W_PAD,
    parameter int D = DW
) (
    input  logic [NCH*K*W*D-1:0] i_rows,
    input  logic [8:0]           i_col,
    output logic [NCH*K*K*D-1:0] o_win
);

    // Row index within i_rows is c*K + r; window byte is (c*K + r)*K + k.
    always_comb begin
        o_win = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    o_win[((c*K + r)*K + k)*D +: D] =
                        i_rows[((c*K + r)*W + int'(i_col) + k)*D +: D];
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streams 3x3x3 convolution windows out of one latched padded row triple.
// Define CONV_WINDOW_STRIDE2_EN to add the per-triple stride2 input.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int W_PAD = conv_pkg::W_PAD,
    parameter int DW    = conv_pkg::DW
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CONV_WINDOW_STRIDE2_EN
    input  logic                 stride2,
`endif
    input  logic                 rows_valid,
    output logic                 rows_ready,
    input  logic [W_PAD*DW-1:0]  R_row0,
    input  logic [W_PAD*DW-1:0]  R_row1,
    input  logic [W_PAD*DW-1:0]  R_row2,
    input  logic [W_PAD*DW-1:0]  G_row0,
    input  logic [W_PAD*DW-1:0]  G_row1,
    input  logic [W_PAD*DW-1:0]  G_row2,
    input  logic [W_PAD*DW-1:0]  B_row0,
    input  logic [W_PAD*DW-1:0]  B_row1,
    input  logic [W_PAD*DW-1:0]  B_row2,
    output logic [27*DW-1:0]     win,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [8:0]           win_col,
    output logic                 row_done
);

    localparam int RW = NCH * K * W_PAD * DW;

    state_t             r_state;
    state_t             w_state_nx;
    logic [RW-1:0]      r_rows;
    logic               r_stride2;
    logic [8:0]         r_col;
    logic [27*DW-1:0]   r_win;
    logic               r_win_valid;
    logic               r_row_done;

    logic [RW-1:0]      w_bus;
    logic [RW-1:0]      w_mux_rows;
    logic [8:0]         w_mux_col;
    logic [27*DW-1:0]   w_mux_win;
    logic               w_s2_in;
    logic [8:0]         w_step;
    logic [8:0]         w_last;
    logic               w_is_last;
    logic [8:0]         w_col_nx;
    logic               w_accept;
    logic               w_load;
    logic               w_adv;
    logic               w_done;

    // Row c*K + r sits at slot c*K + r, R_row0 in the LSBs.
    assign w_bus = {B_row2, B_row1, B_row0,
                    G_row2, G_row1, G_row0,
                    R_row2, R_row1, R_row0};

`ifdef CONV_WINDOW_STRIDE2_EN
    assign w_s2_in = stride2;
`else
    assign w_s2_in = 1'b0;
`endif

    assign w_step    = r_stride2 ? 9'd2 : 9'd1;
    assign w_last    = last_col(W_PAD, r_stride2);
    assign w_is_last = (r_col == w_last);
    // Hold the column at the end so the mux never indexes past the row.
    assign w_col_nx  = w_is_last ? r_col : r_col + w_step;
    assign w_accept  = r_win_valid & win_ready;

    assign w_mux_rows = (r_state == ST_IDLE) ? w_bus : r_rows;
    assign w_mux_col  = (r_state == ST_IDLE) ? 9'd0 : w_col_nx;

    conv_window_mux #(
        .W (W_PAD),
        .D (DW)
    ) u_mux (
        .i_rows (w_mux_rows),
        .i_col  (w_mux_col),
        .o_win  (w_mux_win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_adv      = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rows_valid) begin
                    w_state_nx = ST_SCAN;
                    w_load     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_accept) begin
                    if (w_is_last) begin
                        w_state_nx = ST_IDLE;
                        w_done     = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rows      <= '0;
            r_stride2   <= 1'b0;
            r_col       <= '0;
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_row_done  <= 1'b0;
        end else begin
            r_row_done <= w_done;
            if (w_load) begin
                r_rows      <= w_bus;
                r_stride2   <= w_s2_in;
                r_col       <= '0;
                r_win       <= w_mux_win;
                r_win_valid <= 1'b1;
            end else if (w_adv) begin
                r_col <= w_col_nx;
                r_win <= w_mux_win;
            end else if (w_done) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign rows_ready = (r_state == ST_IDLE);
    assign win        = r_win;
    assign win_valid  = r_win_valid;
    assign win_col    = r_col;
    assign row_done   = r_row_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen with a window-list reference model.
// Stride-2 scenarios compile in when CONV_WINDOW_STRIDE2_EN is defined.
module tb_conv_window_gen;

    localparam int W  = 418;
    localparam int D  = 8;
    localparam int WB = 27 * D;
`ifdef CONV_WINDOW_STRIDE2_EN
    localparam bit S2EN = 1'b1;
`else
    localparam bit S2EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rows_valid = 1'b0;
    logic win_ready = 1'b0;
    logic stride2 = 1'b0;
    logic [W*D-1:0] bus [3][3];
    logic rows_ready;
    logic win_valid;
    logic row_done;
    logic [WB-1:0] win;
    logic [8:0] win_col;

    always #5 clk = ~clk;

    conv_window_gen #(.W_PAD(W), .DW(D)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CONV_WINDOW_STRIDE2_EN
        .stride2    (stride2),
`endif
        .rows_valid (rows_valid),
        .rows_ready (rows_ready),
        .R_row0     (bus[0][0]),
        .R_row1     (bus[0][1]),
        .R_row2     (bus[0][2]),
        .G_row0     (bus[1][0]),
        .G_row1     (bus[1][1]),
        .G_row2     (bus[1][2]),
        .B_row0     (bus[2][0]),
        .B_row1     (bus[2][1]),
        .B_row2     (bus[2][2]),
        .win        (win),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_col    (win_col),
        .row_done   (row_done)
    );

    typedef struct {
        logic [8:0]    col;
        logic [WB-1:0] w;
        bit            last;
    } exp_t;

    exp_t q[$];
    logic [7:0] pix [3][3][W];
    int n_checks = 0;
    int n_errors = 0;
    bit pend = 1'b0;
    int rdy_mode = 0;
    int rdy_cnt = 0;

    task automatic chk(input string nm, input logic [WB-1:0] act,
                       input logic [WB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < W; j++) begin
                    int v;
                    if (mode == 0)
                        v = (c == 0) ? j + r : (c == 1) ? 2*j + r : 255 - j + r;
                    else if (mode == 2)
                        v = 17 * (c + 1);
                    else
                        v = int'($urandom_range(0, 255));
                    pix[c][r][j] = v[7:0];
                end
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < W; j++)
                    bus[c][r][j*D +: D] = pix[c][r][j];
    endtask

    // Every window position that fits in the row, walking by the stride.
    task automatic push_model(input bit s2);
        int step;
        exp_t e;
        step = (s2 && S2EN) ? 2 : 1;
        for (int col = 0; col + 3 <= W; col += step) begin
            e.col = col[8:0];
            e.w = '0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        e.w[(c*9 + r*3 + k)*D +: D] = pix[c][r][col + k];
            e.last = (col + step + 3 > W);
            q.push_back(e);
        end
    endtask

    task automatic send(input int mode, input bit s2);
        int n;
        fill(mode);
        n = 0;
        while (!rows_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rows_ready_timeout", n >= 2000, 0);
        rows_valid = 1'b1;
        stride2 = s2;
        push_model(s2);
        @(posedge clk); #1;
        rows_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || win_valid) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", n >= 5000, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (!(win_valid && win_col == c[8:0]) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_col_timeout", n >= 2000, 0);
    endtask

    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0: win_ready = 1'b1;
            1: win_ready = ($urandom_range(0, 3) != 0);
            default: win_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            pend = 1'b0;
        end else begin
            chk("rows_ready_vs_valid", rows_ready, !win_valid);
            chk("row_done", row_done, pend);
            pend = 1'b0;
            if (win_valid) begin
                chk("window_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("win_col", win_col, q[0].col);
                    chk("win", win, q[0].w);
                    if (win_ready) begin
                        pend = q[0].last;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_b;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                bus[c][r] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win", win, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_rows_ready", rows_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        rdy_mode = 0;
        send(0, 1'b0);
        wait_col(5);
        chk("ramp_c5_R00", win[7:0], 5);
        chk("ramp_c5_R22", win[8*D +: D], 9);
        drain();

        rdy_mode = 1;
        send(1, 1'b0);
        drain();

        rdy_mode = 2;
        send(1, 1'b0);
        drain();

        rdy_mode = 0;
        send(1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        fill(1);
        rows_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midscan_rows_ready", rows_ready, 0);
        rows_valid = 1'b0;
        drain();

        send(1, 1'b0);
        wait_col(100);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_rows_ready", rows_ready, 1);
        chk("midrst_row_done", row_done, 0);
        chk("midrst_win_col", win_col, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(1, 1'b0);
        drain();

        send(2, 1'b0);
        for (int b = 0; b < 27; b++) begin
            exp_b = 17 * (b / 9 + 1);
            chk("chan_map", win[b*D +: D], exp_b[7:0]);
        end
        drain();

`ifdef CONV_WINDOW_STRIDE2_EN
        send(1, 1'b1);
        drain();
        send(1, 1'b0);
        drain();
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            send(1, 1'($urandom_range(0, 1)));
            drain();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
